// File: rtl/rf_wb_arbiter.sv
//============================================================================
// rf_wb_arbiter : merges load and ALU results onto the RF write port  rev 1.0
//============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic             rf_we,
  output logic [4:0]       rf_a3,
  output logic [31:0]      rf_wd3,
  output logic [31:0]      pend_mask,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

  logic [4:0]          fifo_rd_q   [DEPTH];
  logic [31:0]         fifo_data_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                rf_we_q, rf_we_d;
  logic [4:0]          rf_a3_q, rf_a3_d;
  logic [31:0]         rf_wd3_q, rf_wd3_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                alu_acc, mem_sel, push, pop;
  logic [PTR_W-1:0]    pend_idx;

  assign alu_ready = (count_q != FULL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    stall_d  = stall_q;

    mem_sel = mem_valid && (mem_rd != 5'd0);
    alu_acc = alu_valid && alu_ready;
    pop     = !mem_sel && (count_q != '0);
    // x0 results are accepted but dropped; otherwise queue whenever the port is taken
    push    = alu_acc && (alu_rd != 5'd0) && (mem_sel || (count_q != '0));

    if (mem_sel) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = mem_rd;
      rf_wd3_d = mem_data;
    end else if (pop) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = fifo_rd_q[rd_ptr_q];
      rf_wd3_d = fifo_data_q[rd_ptr_q];
    end else if (alu_acc && (alu_rd != 5'd0)) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = alu_rd;
      rf_wd3_d = alu_data;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (alu_valid && !alu_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset: only entries inside [rd_ptr, rd_ptr+count) are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= alu_rd;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end
  end

  always_comb begin
    pend_mask = '0;
    pend_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      pend_idx = rd_ptr_q + PTR_W'(i);
      if (CNT_BITS'(i) < count_q) pend_mask[fifo_rd_q[pend_idx]] = 1'b1;
    end
    if (rf_we_q) pend_mask[rf_a3_q] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign rf_we     = rf_we_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd3    = rf_wd3_q;
  assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
//============================================================================
// tb_rf_wb_arbiter : queue-model checked bench for rf_wb_arbiter     rev 1.0
//============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alu_valid = 1'b0;
  logic             alu_ready;
  logic [4:0]       alu_rd = '0;
  logic [31:0]      alu_data = '0;
  logic             mem_valid = 1'b0;
  logic [4:0]       mem_rd = '0;
  logic [31:0]      mem_data = '0;
  logic             rf_we;
  logic [4:0]       rf_a3;
  logic [31:0]      rf_wd3;
  logic [31:0]      pend_mask;
  logic [CNT_W-1:0] stall_cnt;

  rf_wb_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .pend_mask(pend_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of waiting ALU results plus the output register.
  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  int          m_stall = 0;

  task automatic model_reset();
    mq.delete();
    m_we    = 1'b0;
    m_a3    = '0;
    m_wd    = '0;
    m_stall = 0;
  endtask

  task automatic model_step();
    bit   room;
    bit   acc;
    ent_t e;
    room = (mq.size() != DEPTH);
    acc  = alu_valid && room;
    if (alu_valid && !room && m_stall < 65535) m_stall++;
    e.rd = alu_rd;
    e.d  = alu_data;
    if (mem_valid && mem_rd != 0) begin
      m_we = 1'b1; m_a3 = mem_rd; m_wd = mem_data;
      if (acc && alu_rd != 0) mq.push_back(e);
    end else if (mq.size() != 0) begin
      m_we = 1'b1; m_a3 = mq[0].rd; m_wd = mq[0].d;
      void'(mq.pop_front());
      if (acc && alu_rd != 0) mq.push_back(e);
    end else if (acc && alu_rd != 0) begin
      m_we = 1'b1; m_a3 = alu_rd; m_wd = alu_data;
    end else begin
      m_we = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_we) m[m_a3] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("m_rf_we", {31'd0, rf_we}, {31'd0, m_we});
    if (m_we) begin
      check("m_rf_a3", {27'd0, rf_a3}, {27'd0, m_a3});
      check("m_rf_wd3", rf_wd3, m_wd);
    end
    check("m_pend_mask", pend_mask, model_pend());
    check("m_alu_ready", {31'd0, alu_ready}, {31'd0, (mq.size() != DEPTH)});
    check("m_stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
  endtask

  initial begin
    int acc;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_a3", {27'd0, rf_a3}, 32'd0);
    check("rst_wd3", rf_wd3, 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_ready", {31'd0, alu_ready}, 32'd1);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1 bypass
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle();
    check("t1_we", {31'd0, rf_we}, 32'd1);
    check("t1_a3", {27'd0, rf_a3}, 32'd5);
    check("t1_wd3", rf_wd3, 32'hDEADBEEF);
    check("t1_pend", pend_mask, 32'h0000_0020);
    tick();
    check("t1_we_off", {31'd0, rf_we}, 32'd0);

    // T2 conflict
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    tick();
    idle();
    check("t2_a3_mem", {27'd0, rf_a3}, 32'd3);
    check("t2_wd_mem", rf_wd3, 32'h11);
    check("t2_pend1", pend_mask, 32'h0000_0018);
    tick();
    check("t2_we_alu", {31'd0, rf_we}, 32'd1);
    check("t2_a3_alu", {27'd0, rf_a3}, 32'd4);
    check("t2_wd_alu", rf_wd3, 32'h22);
    check("t2_pend2", pend_mask, 32'h0000_0010);
    tick();
    check("t2_pend3", pend_mask, 32'd0);

    // T3 full FIFO
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(i + 1); mem_data = 32'(i + 1);
      alu_valid = 1'b1; alu_rd = 5'(10 + acc); alu_data = 32'h100 + 32'(10 + acc);
      if (alu_ready) acc++;
      tick();
    end
    idle();
    check("t3_accepted", 32'(acc), 32'd4);
    check("t3_ready", {31'd0, alu_ready}, 32'd0);
    check("t3_stall", {16'd0, stall_cnt}, 32'd2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_drain_we", {31'd0, rf_we}, 32'd1);
      check("t3_drain_a3", {27'd0, rf_a3}, 32'(10 + k));
      check("t3_drain_wd", rf_wd3, 32'h100 + 32'(10 + k));
    end
    tick();
    check("t3_done_we", {31'd0, rf_we}, 32'd0);

    // T4 x0 on both streams
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    check("t4_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    idle();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
    check("t4_we1", {31'd0, rf_we}, 32'd0);
    check("t4_pend1", pend_mask, 32'd0);
    tick();
    idle();
    check("t4_we2", {31'd0, rf_we}, 32'd0);
    check("t4_pend2", pend_mask, 32'd0);

    // T5 reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(i);
      tick();
    end
    idle();
    check("t5_pend_before", pend_mask, 32'h0070_0080);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_we", {31'd0, rf_we}, 32'd0);
    check("t5_pend", pend_mask, 32'd0);
    check("t5_ready", {31'd0, alu_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_stale", {31'd0, rf_we}, 32'd0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      mem_valid = ($urandom_range(0, 99) < 40);
      mem_rd    = 5'($urandom_range(0, 31));
      mem_data  = $urandom;
      alu_valid = ($urandom_range(0, 99) < 60);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      tick();
    end
    idle();
    repeat (6) tick();

    // T6 saturation
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    repeat (70000) tick();
    check("t6_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    repeat (5) tick();
    check("t6_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    idle();
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
